// File: rtl/pc_fetch_pkg.sv
// Shared types and helpers for the PC fetch sequencer.
// Trap support is built only when PC_FETCH_CTRL_TRAP_EN is defined.
package pc_fetch_pkg;

  localparam int ADDR_W      = 32;
  localparam int INSTR_BYTES = 4;

  typedef logic [ADDR_W-1:0] addr_t;

  localparam addr_t RESET_VECTOR_DEF = 32'h0000_0000;
  localparam addr_t TRAP_VECTOR_DEF  = 32'h0000_0100;

  typedef enum logic [2:0] {
    S_IDLE,
    S_BOOT,
    S_FETCH,
    S_HOLD,
    S_HALTED
  } state_t;

  function automatic addr_t align(input addr_t a);
    return {a[ADDR_W-1:2], 2'b00};
  endfunction

  // Sequential successor; the add wraps modulo 2^32.
  function automatic addr_t seq_next(input addr_t pc);
    return align(pc + addr_t'(INSTR_BYTES));
  endfunction

endpackage

// File: rtl/pc_fetch_ctrl_if.sv
// Bundle between the fetch sequencer, PC register, instruction memory and control.
// The trap line exists only when PC_FETCH_CTRL_TRAP_EN is defined.
interface pc_fetch_ctrl_if;
  import pc_fetch_pkg::*;

  addr_t PCout;
  addr_t PCin;
  addr_t br_target;
  logic  wEn;
  logic  imem_req;
  logic  imem_ack;
  logic  instr_valid;
  logic  stall;
  logic  br_taken;
  logic  halt;
  logic  resume;
  logic  halted;
`ifdef PC_FETCH_CTRL_TRAP_EN
  logic  trap;
`endif

  modport master (
    input  PCout, imem_ack, stall, br_taken, br_target, halt, resume,
`ifdef PC_FETCH_CTRL_TRAP_EN
    input  trap,
`endif
    output wEn, PCin, imem_req, instr_valid, halted
  );

  modport slave (
    output PCout, imem_ack, stall, br_taken, br_target, halt, resume,
`ifdef PC_FETCH_CTRL_TRAP_EN
    output trap,
`endif
    input  wEn, PCin, imem_req, instr_valid, halted
  );

endinterface

// File: rtl/pc_next_sel.sv
// Next-PC priority mux: trap > branch > pending redirect > sequential.
module pc_next_sel
  import pc_fetch_pkg::*;
#(
  parameter addr_t TRAP_VECTOR = TRAP_VECTOR_DEF
) (
  input  addr_t pc,
  input  logic  trap,
  input  logic  br_taken,
  input  addr_t br_target,
  input  logic  pend_vld,
  input  addr_t pend_addr,
  output logic  redir_now,
  output addr_t redir_addr,
  output logic  redirect,
  output addr_t next_pc
);

  assign redir_now  = trap | br_taken;
  assign redir_addr = trap ? align(TRAP_VECTOR) : align(br_target);
  assign redirect   = redir_now | pend_vld;
  assign next_pc    = redir_now ? redir_addr :
                      pend_vld  ? pend_addr  : seq_next(pc);

endmodule

// File: rtl/pc_fetch_ctrl.sv
// Fetch sequencer: boots the PC, issues fetches, applies stalls, halts and redirects.
// Define PC_FETCH_CTRL_TRAP_EN to add the trap redirect input.
module pc_fetch_ctrl
  import pc_fetch_pkg::*;
#(
  parameter addr_t RESET_VECTOR = RESET_VECTOR_DEF,
  parameter addr_t TRAP_VECTOR  = TRAP_VECTOR_DEF
) (
  input  logic           clock,
  input  logic           reset,
  pc_fetch_ctrl_if.master bus
);

  state_t state, state_d;
  logic   pend_vld, pend_vld_d;
  addr_t  pend_addr, pend_addr_d;
  logic   squash, squash_d;

  logic   trap_in;
  logic   redir_now, redirect;
  addr_t  redir_addr, next_pc;

`ifdef PC_FETCH_CTRL_TRAP_EN
  assign trap_in = bus.trap;
`else
  assign trap_in = 1'b0;
`endif

  pc_next_sel #(.TRAP_VECTOR(TRAP_VECTOR)) u_next_sel (
    .pc         (bus.PCout),
    .trap       (trap_in),
    .br_taken   (bus.br_taken),
    .br_target  (bus.br_target),
    .pend_vld   (pend_vld),
    .pend_addr  (pend_addr),
    .redir_now  (redir_now),
    .redir_addr (redir_addr),
    .redirect   (redirect),
    .next_pc    (next_pc)
  );

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      pend_vld  <= 1'b0;
      pend_addr <= '0;
      squash    <= 1'b0;
    end else begin
      state     <= state_d;
      pend_vld  <= pend_vld_d;
      pend_addr <= pend_addr_d;
      squash    <= squash_d;
    end
  end

  // NOTE: every output and next-state term gets a default first, so no path infers a latch.
  always_comb begin
    state_d         = state;
    pend_vld_d      = pend_vld;
    pend_addr_d     = pend_addr;
    squash_d        = squash;
    bus.wEn         = 1'b0;
    bus.PCin        = align(RESET_VECTOR);
    bus.imem_req    = 1'b0;
    bus.instr_valid = 1'b0;
    bus.halted      = 1'b0;

    unique case (state)
      S_IDLE: state_d = S_BOOT;

      S_BOOT: begin
        bus.wEn = 1'b1;
        state_d = S_FETCH;
      end

      S_FETCH: begin
        bus.imem_req = 1'b1;
        // Hold the current address while the request is outstanding.
        bus.PCin     = align(bus.PCout);
        if (bus.imem_ack) begin
          bus.instr_valid = !squash;
          pend_vld_d      = 1'b0;
          squash_d        = 1'b0;
          if (redirect) begin
            bus.wEn  = 1'b1;
            bus.PCin = next_pc;
          end else if (bus.stall) begin
            state_d = S_HOLD;
          end else if (bus.halt) begin
            bus.wEn  = 1'b1;
            bus.PCin = next_pc;
            state_d  = S_HALTED;
          end else begin
            bus.wEn  = 1'b1;
            bus.PCin = next_pc;
          end
        end else if (redir_now) begin
          // The in-flight fetch is now stale; redirect once it returns.
          pend_addr_d = redir_addr;
          pend_vld_d  = 1'b1;
          squash_d    = 1'b1;
        end
      end

      S_HOLD: begin
        bus.PCin = next_pc;
        if (redir_now || !bus.stall) begin
          bus.wEn = 1'b1;
          state_d = S_FETCH;
        end
      end

      S_HALTED: begin
        bus.halted = 1'b1;
        bus.PCin   = next_pc;
        if (bus.resume) begin
          state_d = S_FETCH;
        end else if (redir_now) begin
          bus.wEn = 1'b1;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: doc/pc_fetch_ctrl.md
# pc_fetch_ctrl

Fetch sequencer for the 32-bit PC register. Drives the register's `wEn`/`PCin`, issues instruction-memory fetch requests at the current `PCout`, and chooses the next PC among sequential, branch redirect and trap vector. Handles stall, halt/resume, and squashes fetches that a redirect overtakes. Sits between the PC register, the instruction memory port and the decode/execute control.

## Interface
- `RESET_VECTOR`, 32'h0000_0000: first PC written after reset.
- `TRAP_VECTOR`, 32'h0000_0100: PC written on trap (only when `TRAP_EN` is defined).
- `clock` in 1: sole clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `PCout` in 32: current PC from the PC register.
- `wEn` out 1: PC register write enable.
- `PCin` out 32: next PC value; bits [1:0] are always 0.
- `imem_req` out 1: fetch request at address `PCout`.
- `imem_ack` in 1: fetch data returned this cycle.
- `instr_valid` out 1: the returned instruction is architecturally valid.
- `stall` in 1: pipeline cannot accept a new instruction.
- `br_taken` in 1: redirect request.
- `br_target` in 32: redirect address; bits [1:0] are ignored.
- `halt` in 1: stop fetching.
- `resume` in 1: leave HALTED.
- `trap` in 1: exception redirect (`TRAP_EN` only).
- `halted` out 1: high while in HALTED.

## Operation
- States:
  - IDLE: reset state; all request and enable outputs low.
  - BOOT: `wEn`=1, `PCin`=`RESET_VECTOR`.
  - FETCH: `imem_req`=1.
  - HOLD: stalled after a completed fetch.
  - HALTED.
- Transitions:
  - IDLE→BOOT unconditionally.
  - BOOT→FETCH.
- FETCH, ack cycle: `instr_valid`=!`squash`. Next-PC priority: trap > `br_taken` > pending redirect > `PCout`+4.
  - Redirect (trap, `br_taken` or pending): write the redirect address and stay in FETCH, regardless of `stall`.
  - Otherwise, `stall`=1: no write, go to HOLD.
  - Otherwise, `halt`=1: write `PCout`+4, go to HALTED.
  - Otherwise: write `PCout`+4 and stay in FETCH.
  - Clear `squash` and the pending redirect on every ack cycle.
- FETCH, no-ack cycle:
  - `br_taken` or trap: latch the address into `pend_addr`; set `pend_vld` and `squash`.
  - `PCin` and the PC do not change while `imem_req` is high and unacked, so the address stays stable.
  - `halt` is ignored until the ack.
- HOLD (`imem_req`=0):
  - `br_taken` or trap: write the redirect address, go to FETCH.
  - `stall`=0: write `PCout`+4, go to FETCH.
- HALTED (`imem_req`=0):
  - `resume`=1: go to FETCH with no PC write.
  - `br_taken`/trap: write the redirect address, stay in HALTED.
- Arithmetic and addressing:
  - +4 is modulo 2^32: 32'hFFFF_FFFC → 32'h0000_0000.
  - Redirect addresses use `{addr[31:2],2'b00}`.
- Simultaneous trap and `br_taken`: trap wins. A newer redirect overwrites `pend_addr`.

## Timing
- Reset values: `wEn`=0, `PCin`=`RESET_VECTOR`, `imem_req`=0, `instr_valid`=0, `halted`=0. `pend_vld`=0 and `squash`=0.
- Reset asserted mid-fetch: the FSM enters IDLE immediately and the request drops asynchronously.
- After reset deassertion:
  - Edge 1: IDLE→BOOT.
  - During BOOT: `wEn`=1.
  - Edge 2: `PCout`=`RESET_VECTOR`, state=FETCH.
  - First `imem_req` is seen the cycle after edge 2.
- `wEn`, `PCin`, `imem_req` and `instr_valid` are combinational from state, registers and inputs.
- `PCout` reflects a write one edge later.
- With ack every cycle and no stall, the PC advances +4 per cycle: throughput is 1 fetch/cycle.
- Branch latency is 0 cycles if `br_taken` arrives on the ack cycle; otherwise the redirect applies at the ack.

## Configuration
- `PC_FETCH_CTRL_TRAP_EN`:
  - Defined: the `trap` port exists, with highest redirect priority, target `TRAP_VECTOR`.
  - Undefined: the `trap` port is absent and `TRAP_VECTOR` is unused.

## Structure
- Package `pc_fetch_pkg`:
  - State enum (IDLE, BOOT, FETCH, HOLD, HALTED).
  - `INSTR_BYTES`=4.
  - Address width 32.
- Sub-module `pc_next_sel`: combinational priority mux for the next PC and redirect. The FSM lives in the top.

## Test plan
- Reset release, ack each cycle, no stall → `PCout` sequence 0, 4, 8, 12; `instr_valid` on every ack.
- `br_taken`=1 with `br_target`=32'h203 on a non-ack cycle at PC 8, ack 2 cycles later → `instr_valid`=0 on that ack; next `PCout`=32'h200.
- `stall`=1 across an ack at PC 4 for 3 cycles → `PCout` stays 4 and `imem_req`=0 for 3 cycles; then `PCout`=8.
- PC=32'hFFFF_FFFC, ack → `PCout`=0.
- `halt` at ack, PC 16 → `halted`=1, `PCout`=20; `resume` → FETCH resumes at 20.
- With `PC_FETCH_CTRL_TRAP_EN`: `trap` and `br_taken` in the same ack cycle → `PCout`=32'h100. Reset pulse mid-fetch → `imem_req`=0 immediately.
